addsub_pipe: RTL and testbench



---
 rtl/addsub_pkg.sv | 15 +
 rtl/addsub_stage.sv | 34 +++
 rtl/addsub_pipe.sv | 116 +++++++++++
 tb/tb_addsub_pipe.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: op encodings, flag bit positions and the flag record shared by addsub_pipe and its stages.
package addsub_pkg;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;
    typedef struct packed {
        logic v;
        logic n;
        logic z;
        logic c;
    } flags_t;
endpackage

// File: rtl/addsub_stage.sv
// addsub_stage: one CHUNK-wide slice of the carry chain; inverts B for subtract and registers sum, carry, valid and op.
module addsub_stage
    import addsub_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             valid_in,
    input  logic             op_in,
    input  logic             carry_in,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             valid,
    output logic             op,
    output logic             carry,
    output logic [CHUNK-1:0] sum
);
    logic [CHUNK:0] total;
    assign total = {1'b0, a} + {1'b0, op_in == OP_ADD ? b : ~b} + {{CHUNK{1'b0}}, carry_in};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            op    <= 1'b0;
            carry <= 1'b0;
            sum   <= '0;
        end else if (en) begin
            valid        <= valid_in;
            op           <= op_in;
            {carry, sum} <= total;
        end
    end
endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined add/sub, one carry-chain chunk per stage, valid/ready handshake.
// Define ADDSUB_FLAGS_EN to build the {V,N,Z,C} flag logic; otherwise flags is tied to zero.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic [3:0]       flags
);
    localparam int CHUNK = WIDTH / STAGES;
    logic              advance;
    logic [STAGES-1:0] v_in, o_in, c_in, v_q, o_q, c_q;
    logic [CHUNK-1:0]  a_in [STAGES];
    logic [CHUNK-1:0]  b_in [STAGES];
    logic [CHUNK-1:0]  s_q  [STAGES];
    // a_sk/b_sk[d][j]: operand chunk j (j > d) held alongside stage d; r_dk[d][j]: result chunk j (j < d)
    logic [CHUNK-1:0]  a_sk [STAGES][STAGES];
    logic [CHUNK-1:0]  b_sk [STAGES][STAGES];
    logic [CHUNK-1:0]  r_dk [STAGES][STAGES];

    assign out_valid = v_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g
        if (k == 0) begin : head
            assign v_in[0] = in_valid;
            assign o_in[0] = op;
            assign c_in[0] = op == OP_SUB ? ~cin : cin;
            assign a_in[0] = A[CHUNK-1:0];
            assign b_in[0] = B[CHUNK-1:0];
        end else begin : body
            assign v_in[k] = v_q[k-1];
            assign o_in[k] = o_q[k-1];
            assign c_in[k] = c_q[k-1];
            assign a_in[k] = a_sk[k-1][k];
            assign b_in[k] = b_sk[k-1][k];
        end
        addsub_stage #(.CHUNK(CHUNK)) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (advance),
            .valid_in (v_in[k]),
            .op_in    (o_in[k]),
            .carry_in (c_in[k]),
            .a        (a_in[k]),
            .b        (b_in[k]),
            .valid    (v_q[k]),
            .op       (o_q[k]),
            .carry    (c_q[k]),
            .sum      (s_q[k])
        );
        assign result[k*CHUNK +: CHUNK] = k == STAGES - 1 ? s_q[k] : r_dk[STAGES-1][k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < STAGES; d++)
                for (int j = 0; j < STAGES; j++) begin
                    a_sk[d][j] <= '0;
                    b_sk[d][j] <= '0;
                    r_dk[d][j] <= '0;
                end
        end else if (advance) begin
            for (int j = 1; j < STAGES; j++) begin
                a_sk[0][j] <= A[j*CHUNK +: CHUNK];
                b_sk[0][j] <= B[j*CHUNK +: CHUNK];
            end
            for (int d = 1; d < STAGES; d++)
                for (int j = 0; j < STAGES; j++) begin
                    if (j > d) begin
                        a_sk[d][j] <= a_sk[d-1][j];
                        b_sk[d][j] <= b_sk[d-1][j];
                    end
                    if (j < d)
                        r_dk[d][j] <= j == d - 1 ? s_q[d-1] : r_dk[d-1][j];
                end
        end
    end

`ifdef ADDSUB_FLAGS_EN
    logic   a_msb, b_msb;
    flags_t f;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (advance) begin
            a_msb <= a_in[STAGES-1][CHUNK-1];
            b_msb <= b_in[STAGES-1][CHUNK-1];
        end
    end
    // b_msb is the raw B bit; the final-stage op turns it into the effective operand bit
    assign f = '{v: (a_msb == (b_msb ^ o_q[STAGES-1])) && (result[WIDTH-1] != a_msb),
                 n: result[WIDTH-1], z: result == '0, c: cout};
    assign flags = out_valid ? f : '0;
`else
    logic unused_op;
    assign unused_op = o_q[STAGES-1];
    assign flags     = '0;
`endif
endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed and randomized checks of addsub_pipe against an integer reference model.
`timescale 1ns/1ps
module tb_addsub_pipe;
    import addsub_pkg::*;
    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
`ifdef ADDSUB_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic        clk = 0, rst_n = 1, in_valid = 0, op = 0, cin = 0, out_ready = 1;
    logic [31:0] a = 0, b = 0;
    logic        in_ready, out_valid, cout;
    logic [31:0] result;
    logic [3:0]  flags;
    int          total = 0, bad = 0, outs = 0, o0 = 0, n = 0;
    bit          done = 0, stall_prev = 0;

    typedef struct packed { logic [31:0] r; logic c; logic [3:0] f; } exp_t;
    exp_t q[$];
    exp_t snap, e_cur;

    addsub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .op(op), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .flags(flags)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    // Integer reference: true sums/differences in 64-bit arithmetic
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic o, input logic c);
        longint s, sv;
        exp_t   e;
        s  = o ? longint'(x) - longint'(y) - longint'(c) : longint'(x) + longint'(y) + longint'(c);
        sv = o ? longint'($signed(x)) - longint'($signed(y)) - longint'(c)
               : longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        e.r = s[31:0];
        e.c = o ? (s >= 0) : s[32];
        e.f = '0;
        if (FLAGS_ON) begin
            e.f[FLAG_V] = sv != longint'($signed(e.r));
            e.f[FLAG_N] = e.r[31];
            e.f[FLAG_Z] = e.r == 0;
            e.f[FLAG_C] = e.c;
        end
        return e;
    endfunction

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h7FFFFFFF;
            3: return 32'h80000000;
            4: return 32'h0000FFFF << (8 * $urandom_range(0, 2));
            default: return $urandom();
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            stall_prev = 0;
        end else begin
            chk("in_ready rule", in_ready, !out_valid || out_ready);
            if (stall_prev) begin
                chk("stall valid", out_valid, 1);
                chk("stall hold", {result, cout, flags}, snap);
            end
            stall_prev = out_valid && !out_ready;
            snap = {result, cout, flags};
            if (out_valid && out_ready) begin
                chk("output expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e_cur = q.pop_front();
                    outs++;
                    chk("out result", result, e_cur.r);
                    chk("out cout", cout, e_cur.c);
                    chk("out flags", flags, e_cur.f);
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, op, cin));
        end
    end

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic o, input logic c);
        int w = 0;
        a = x; b = y; op = o; cin = c; in_valid = 1;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("send accept", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic directed(input string nm, input logic [31:0] x, input logic [31:0] y, input logic o,
                            input logic c, input logic [31:0] er, input logic ec, input logic [3:0] ef);
        int w = 0;
        out_ready = 1;
        send(x, y, o, c);
        do begin
            @(negedge clk);
            w++;
        end while (!out_valid && w < 20);
        chk({nm, " latency"}, w, STAGES);
        chk({nm, " result"}, result, er);
        chk({nm, " cout"}, cout, ec);
        chk({nm, " flags"}, flags, FLAGS_ON ? ef : 4'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        int w = 0;
        out_ready = 1;
        while (q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk({nm, " drained"}, q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst_n = 0;
        #2;
        chk("rst out_valid", out_valid, 0);
        chk("rst result", result, 0);
        chk("rst cout", cout, 0);
        chk("rst flags", flags, 0);
        chk("rst in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        #1 rst_n = 1;
        @(posedge clk);
        #1;
        // flags literals are {V,N,Z,C}
        directed("add ovf", 32'h7FFFFFFF, 32'h1, 0, 0, 32'h80000000, 0, 4'b1100);
        directed("sub eq", 32'h5, 32'h5, 1, 0, 32'h0, 1, 4'b0011);
        directed("sub borrow", 32'h0, 32'h1, 1, 0, 32'hFFFFFFFF, 0, 4'b0100);
        directed("sub ovf", 32'h80000000, 32'h1, 1, 0, 32'h7FFFFFFF, 1, 4'b1001);
        directed("chunk carry", 32'h0000FFFF, 32'h1, 0, 0, 32'h00010000, 0, 4'b0000);
        directed("full carry", 32'hFFFFFFFF, 32'h0, 0, 1, 32'h0, 1, 4'b0011);
        directed("sub bin", 32'h10, 32'h3, 1, 1, 32'hC, 1, 4'b0001);

        o0 = outs;
        fork
            for (int i = 0; i < 8; i++) send($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 0;
                @(negedge clk);
                chk("stall in_ready", in_ready, 0);
                chk("stall out_valid", out_valid, 1);
                repeat (3) @(posedge clk);
                #1 out_ready = 1;
            end
        join
        drain("stream");
        chk("stream count", outs - o0, 8);

        o0 = outs;
        done = 0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                done = 1;
            end
            while (!done) begin
                @(posedge clk);
                #1 out_ready = $urandom_range(0, 3) != 0;
            end
        join
        drain("random");
        chk("random count", outs - o0, 200);

        out_ready = 1;
        send(32'h1, 32'h2, 0, 0);
        send(32'h3, 32'h4, 0, 0);
        send(32'h5, 32'h6, 1, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        chk("pre-reset valid", out_valid, 1);
        #1 rst_n = 0;
        #1;
        chk("mid-rst out_valid", out_valid, 0);
        chk("mid-rst result", result, 0);
        chk("mid-rst cout", cout, 0);
        chk("mid-rst flags", flags, 0);
        @(negedge clk);
        #1 rst_n = 1;
        repeat (6) begin
            @(negedge clk);
            chk("no stale", out_valid, 0);
        end
        @(posedge clk);
        #1;
        directed("post-rst", 32'h12345678, 32'h11111111, 0, 0, 32'h23456789, 0, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
